// File: rtl/spi_cmd_pkg.sv
// Shared definitions for the SPI command decoder: opcodes, FSM states and
// header field positions.
package spi_cmd_pkg;

    typedef enum logic [2:0] {
        OP_READ_AT    = 3'b000,
        OP_READ_NEXT  = 3'b001,
        OP_WRITE_AT   = 3'b010,
        OP_WRITE_NEXT = 3'b011
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARG1  = 3'd1,
        ST_ARG2  = 3'd2,
        ST_ARG3  = 3'd3,
        ST_ISSUE = 3'd4,
        ST_DRAIN = 3'd5
    } state_e;

    localparam int HDR_OP_MSB  = 7;
    localparam int HDR_OP_LSB  = 5;
    localparam int HDR_A16_BIT = 0;

    localparam int ADDR_W = 17;

endpackage

// File: rtl/spi_cmd.sv
// SPI command decoder: turns header/argument byte frames into a single
// valid/ready bus transaction and returns read data for the next frame.
module spi_cmd
    import spi_cmd_pkg::*;
(
    input  logic                clk_sys_i,
    input  logic                reset_i,
    input  logic                cs_ni,
    input  logic [7:0]          rx_byte_i,
    input  logic                rx_valid_i,
    output logic [ADDR_W-1:0]   spi_addr_o,
    output logic [7:0]          spi_data_o,
    output logic                spi_rw_no,
    output logic                spi_valid_o,
    input  logic                spi_ready_i,
    input  logic [7:0]          spi_data_i,
    output logic [7:0]          tx_byte_o,
    output logic                busy_o,
    output logic                overrun_o
);

    state_e              state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic                a16_q, a16_d;
    logic [7:0]          ahi_q, ahi_d;
    logic [7:0]          arg_data_q, arg_data_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          wdata_q, wdata_d;
    logic                rw_q, rw_d;
    logic [7:0]          tx_q, tx_d;
    logic                ovr_q, ovr_d;

    logic                byte_ok;
    logic [2:0]          rx_op;
    logic [ADDR_W-1:0]   addr_inc;

    // A byte arriving together with cs_ni high belongs to no frame.
    assign byte_ok  = rx_valid_i && !cs_ni;
    assign rx_op    = rx_byte_i[HDR_OP_MSB:HDR_OP_LSB];
    assign addr_inc = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        a16_d      = a16_q;
        ahi_d      = ahi_q;
        arg_data_d = arg_data_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rw_d       = rw_q;
        tx_d       = tx_q;
        ovr_d      = ovr_q;

        case (state_q)
            ST_IDLE: begin
                if (byte_ok) begin
                    op_d  = rx_op;
                    a16_d = rx_byte_i[HDR_A16_BIT];
                    case (rx_op)
                        OP_READ_AT,
                        OP_WRITE_AT,
                        OP_WRITE_NEXT: state_d = ST_ARG1;
                        OP_READ_NEXT: begin
                            addr_d  = addr_inc;
                            rw_d    = 1'b1;
                            state_d = ST_ISSUE;
                        end
                        default: state_d = ST_DRAIN;
                    endcase
                end
            end

            ST_ARG1: begin
                if (cs_ni) begin
                    state_d = ST_IDLE;
                end else if (rx_valid_i) begin
                    case (op_q)
                        OP_READ_AT: begin
                            ahi_d   = rx_byte_i;
                            state_d = ST_ARG2;
                        end
                        OP_WRITE_AT: begin
                            arg_data_d = rx_byte_i;
                            state_d    = ST_ARG2;
                        end
                        OP_WRITE_NEXT: begin
                            wdata_d = rx_byte_i;
                            addr_d  = addr_inc;
                            rw_d    = 1'b0;
                            state_d = ST_ISSUE;
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end
            end

            ST_ARG2: begin
                if (cs_ni) begin
                    state_d = ST_IDLE;
                end else if (rx_valid_i) begin
                    if (op_q == OP_READ_AT) begin
                        addr_d  = {a16_q, ahi_q, rx_byte_i};
                        rw_d    = 1'b1;
                        state_d = ST_ISSUE;
                    end else begin
                        ahi_d   = rx_byte_i;
                        state_d = ST_ARG3;
                    end
                end
            end

            ST_ARG3: begin
                if (cs_ni) begin
                    state_d = ST_IDLE;
                end else if (rx_valid_i) begin
                    addr_d  = {a16_q, ahi_q, rx_byte_i};
                    wdata_d = arg_data_q;
                    rw_d    = 1'b0;
                    state_d = ST_ISSUE;
                end
            end

            // cs_ni is deliberately ignored here: an issued transaction always completes.
            ST_ISSUE: begin
                if (byte_ok) begin
                    ovr_d = 1'b1;
                end
                if (spi_ready_i) begin
                    state_d = ST_IDLE;
                    if (rw_q) begin
                        tx_d = spi_data_i;
                    end
                end
            end

            ST_DRAIN: begin
                if (cs_ni) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            op_q       <= 3'b000;
            a16_q      <= 1'b0;
            ahi_q      <= 8'h00;
            arg_data_q <= 8'h00;
            addr_q     <= '0;
            wdata_q    <= 8'h00;
            rw_q       <= 1'b1;
            tx_q       <= 8'h00;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            a16_q      <= a16_d;
            ahi_q      <= ahi_d;
            arg_data_q <= arg_data_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rw_q       <= rw_d;
            tx_q       <= tx_d;
            ovr_q      <= ovr_d;
        end
    end

    // Decoded straight from the state register so reset drops valid without a clock.
    assign spi_valid_o = (state_q == ST_ISSUE);
    assign busy_o      = (state_q == ST_ARG1) || (state_q == ST_ARG2) ||
                         (state_q == ST_ARG3) || (state_q == ST_ISSUE);
    assign spi_addr_o  = addr_q;
    assign spi_data_o  = wdata_q;
    assign spi_rw_no   = rw_q;
    assign tx_byte_o   = tx_q;
    assign overrun_o   = ovr_q;

endmodule
